ftdi_fifo_rx_adapter: RTL and testbench

Receive-side counterpart of the FIFO-to-FTDI transmit adapter. Reads bytes from an FT245-style FTDI parallel FIFO (active-low FRXF/FRD) and writes each byte into the local receive FIFO on the write clock domain. It performs the FTDI read strobe sequence with programmable strobe widths and applies FIFO backpressure so that no byte is lost on overflow.

---
 rtl/ftdi_pkg.sv | 16 +
 rtl/ftdi_fifo_rx_adapter_sync_2ff.sv | 25 ++
 rtl/ftdi_fifo_rx_adapter.sv | 121 ++++++++++++
 tb/tb_ftdi_fifo_rx_adapter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FTDI FIFO adapters.
package ftdi_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned USEDW_W     = 11;
  localparam int unsigned RX_CNT_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } ftdi_rx_state_e;

endpackage

// File: rtl/ftdi_fifo_rx_adapter_sync_2ff.sv
// Single-bit multi-flop synchronizer, depth SYNC_STAGES, with a selectable reset value.
module sync_2ff
  import ftdi_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/ftdi_fifo_rx_adapter.sv
// FT245-style FIFO read sequencer: strobes FRD, latches FDATA and writes each byte to the RX FIFO.
// Optional received-byte counter on rx_cnt when FTDI_RX_CNT_EN is defined.
module ftdi_fifo_rx_adapter
  import ftdi_pkg::*;
#(
  parameter int unsigned RD_LOW_CYCLES  = 3,
  parameter int unsigned RD_HIGH_CYCLES = 2,
  parameter int unsigned USEDW_MAX      = 2040
) (
  input  logic                wrclk,
  input  logic                rst_n,
  input  logic                FRXF,
  input  logic [DATA_W-1:0]   FDATA,
  output logic                FRD,
  input  logic                rx_en,
  input  logic                tx_busy,
  input  logic [USEDW_W-1:0]  usedw,
  input  logic                wrfull,
  output logic                wrreq,
  output logic [DATA_W-1:0]   data,
  output logic                rx_busy,
  output logic [RX_CNT_W-1:0] rx_cnt
);

  localparam int unsigned LOW_LOAD  = RD_LOW_CYCLES - 1;
  localparam int unsigned HIGH_LOAD = RD_HIGH_CYCLES + 1;
  localparam int unsigned CNT_MAX   = (LOW_LOAD > HIGH_LOAD) ? LOW_LOAD : HIGH_LOAD;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  ftdi_rx_state_e    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              frd_q;
  logic              wrreq_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              rxf_s;
  logic              start_c;

  sync_2ff #(.RST_VAL(1'b1)) u_rxf_sync (
    .clk   (wrclk),
    .rst_n (rst_n),
    .d_i   (FRXF),
    .q_o   (rxf_s)
  );

  // Both the fill-level margin and wrfull gate a new read.
  assign start_c = !rxf_s && rx_en && !tx_busy && !wrfull &&
                   (32'(usedw) < 32'(USEDW_MAX));

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frd_q   <= 1'b1;
      wrreq_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      wrreq_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q <= STROBE;
            frd_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(LOW_LOAD);
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            data_q  <= FDATA;
            frd_q   <= 1'b1;
            wrreq_q <= 1'b1;
            state_q <= WRITE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WRITE: begin
          state_q <= RECOVER;
          cnt_q   <= CNT_W'(HIGH_LOAD);
        end
        RECOVER: begin
          // Leave as the count reaches zero; spans the sync latency after FRD rises.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          frd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign FRD     = frd_q;
  assign wrreq   = wrreq_q;
  assign data    = data_q;
  assign rx_busy = busy_q;

`ifdef FTDI_RX_CNT_EN
  logic [RX_CNT_W-1:0] rx_cnt_q;

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q <= '0;
    end else if (wrreq_q) begin
      rx_cnt_q <= rx_cnt_q + RX_CNT_W'(1);
    end
  end

  assign rx_cnt = rx_cnt_q;
`else
  assign rx_cnt = '0;
`endif

endmodule

// File: tb/tb_ftdi_fifo_rx_adapter.sv
// Self-checking bench for ftdi_fifo_rx_adapter: FTDI byte-queue emulator, timeline model, directed tests.
module tb_ftdi_fifo_rx_adapter;

  localparam int L    = 3;
  localparam int H    = 2;
  localparam int UMAX = 2040;

  logic        wrclk   = 1'b0;
  logic        rst_n   = 1'b0;
  logic        FRXF    = 1'b1;
  logic [7:0]  FDATA   = 8'h00;
  logic        rx_en   = 1'b1;
  logic        tx_busy = 1'b0;
  logic [10:0] usedw   = 11'd0;
  logic        wrfull  = 1'b0;
  logic        FRD;
  logic        wrreq;
  logic [7:0]  data;
  logic        rx_busy;
  logic [31:0] rx_cnt;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_en  = 1'b0;
  bit   preload = 1'b0;
  logic [7:0] ftdi_q[$];

  ftdi_fifo_rx_adapter dut (
    .wrclk   (wrclk),
    .rst_n   (rst_n),
    .FRXF    (FRXF),
    .FDATA   (FDATA),
    .FRD     (FRD),
    .rx_en   (rx_en),
    .tx_busy (tx_busy),
    .usedw   (usedw),
    .wrfull  (wrfull),
    .wrreq   (wrreq),
    .data    (data),
    .rx_busy (rx_busy),
    .rx_cnt  (rx_cnt)
  );

  always #5 wrclk = ~wrclk;
  always @(posedge wrclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FTDI side: FRXF low while bytes are queued; a byte is consumed when FRD rises.
  always @(negedge wrclk) begin
    FRXF  = (ftdi_q.size() == 0);
    FDATA = (ftdi_q.size() == 0) ? 8'h00 : ftdi_q[0];
  end
  always @(posedge FRD) begin
    #2;
    if (ftdi_q.size() > 0) void'(ftdi_q.pop_front());
  end

  // Model: a read is a timeline of offsets from its start edge.
  int          m_off = -1;
  bit          m_frd = 1'b1, m_wrreq = 1'b0, m_busy = 1'b0;
  bit          m_d1 = 1'b1, m_d2 = 1'b1;
  logic [7:0]  m_data = 8'h00;
  logic [31:0] m_cnt = 32'h0;

  always @(posedge wrclk or negedge rst_n) begin : model
    int nxt;
    if (!rst_n) begin
      m_off <= -1; m_frd <= 1'b1; m_wrreq <= 1'b0; m_busy <= 1'b0;
      m_d1 <= 1'b1; m_d2 <= 1'b1; m_data <= 8'h00; m_cnt <= 32'h0;
    end else begin
      if (m_off < 0)
        nxt = (!m_d2 && rx_en && !tx_busy && !wrfull && int'(usedw) < UMAX) ? 0 : -1;
      else
        nxt = (m_off + 1 == L + H + 2) ? -1 : m_off + 1;
      m_off   <= nxt;
      m_frd   <= !(nxt >= 0 && nxt < L);
      m_wrreq <= (nxt == L);
      m_busy  <= (nxt >= 0);
      if (nxt == L) m_data <= FDATA;
      m_d1 <= FRXF;
      m_d2 <= m_d1;
`ifdef FTDI_RX_CNT_EN
      if (preload) m_cnt <= 32'hFFFF_FFFF;
      else if (m_wrreq) m_cnt <= m_cnt + 32'd1;
`endif
    end
  end

  always @(negedge wrclk) begin
    if (chk_en) begin
      chk("cmp_FRD", 32'(FRD), 32'(m_frd));
      chk("cmp_wrreq", 32'(wrreq), 32'(m_wrreq));
      chk("cmp_rx_busy", 32'(rx_busy), 32'(m_busy));
      chk("cmp_rx_cnt", rx_cnt, m_cnt);
      if (m_wrreq) chk("cmp_data", 32'(data), 32'(m_data));
    end
  end

  task automatic push(input logic [7:0] b);
    @(posedge wrclk); #1;
    ftdi_q.push_back(b);
    @(negedge wrclk);
  endtask

  task automatic wait_wrreq(input logic [7:0] exp, output int stamp);
    bit got = 1'b0;
    stamp = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge wrclk);
      if (wrreq === 1'b1) begin got = 1'b1; stamp = cyc; end
    end
    chk("wrreq_seen", 32'(got), 32'd1);
    if (got) chk("byte", 32'(data), 32'(exp));
  endtask

  task automatic wait_frd_low();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge wrclk);
      if (FRD === 1'b0) got = 1'b1;
    end
    chk("frd_low_seen", 32'(got), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st[4];
    int s;
    @(posedge wrclk);
    chk_en = 1'b1;
    repeat (2) @(negedge wrclk);
    chk("rst_FRD", 32'(FRD), 32'd1);
    chk("rst_wrreq", 32'(wrreq), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_cnt", rx_cnt, 32'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge wrclk);

    // Single byte: exact strobe timeline relative to FRXF falling.
    push(8'hA5);
    for (int i = 1; i <= 10; i++) begin
      @(negedge wrclk);
      chk("single_FRD", 32'(FRD), (i >= 3 && i <= 5) ? 32'd0 : 32'd1);
      if (i == 6) begin
        chk("single_wrreq", 32'(wrreq), 32'd1);
        chk("single_data", 32'(data), 32'hA5);
      end
      if (i == 7) chk("single_wrreq_once", 32'(wrreq), 32'd0);
      if (i == 10) chk("single_idle", 32'(rx_busy), 32'd0);
    end
    repeat (4) @(negedge wrclk);

    // Burst of four with FRXF held low: 8-cycle byte period.
    @(posedge wrclk); #1;
    for (int i = 1; i <= 4; i++) ftdi_q.push_back(8'(i));
    for (int i = 0; i < 4; i++) wait_wrreq(8'(i + 1), st[i]);
    for (int i = 1; i < 4; i++) chk("burst_period", 32'(st[i] - st[i-1]), 32'd8);
    repeat (8) @(negedge wrclk);

    // Blockers: usedw at limit, wrfull, rx_en low; each released in turn.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: usedw = 11'(UMAX);
        1: wrfull = 1'b1;
        default: rx_en = 1'b0;
      endcase
      push(8'h30 + 8'(k));
      repeat (8) begin
        @(negedge wrclk);
        chk("blocked_FRD", 32'(FRD), 32'd1);
      end
      case (k)
        0: usedw = 11'(UMAX - 1);
        1: wrfull = 1'b0;
        default: rx_en = 1'b1;
      endcase
      @(negedge wrclk);
      chk("release_FRD", 32'(FRD), 32'd0);
      wait_wrreq(8'h30 + 8'(k), s);
      usedw = 11'd0;
      repeat (8) @(negedge wrclk);
    end

    // tx_busy raised mid-strobe: current byte completes, next read waits.
    @(posedge wrclk); #1;
    ftdi_q.push_back(8'h5A);
    ftdi_q.push_back(8'hC3);
    wait_frd_low();
    tx_busy = 1'b1;
    wait_wrreq(8'h5A, s);
    repeat (15) begin
      @(negedge wrclk);
      chk("txbusy_FRD", 32'(FRD), 32'd1);
    end
    tx_busy = 1'b0;
    wait_wrreq(8'hC3, s);
    repeat (8) @(negedge wrclk);

    // Reset mid-strobe: outputs return to reset values immediately.
    push(8'hE1);
    wait_frd_low();
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_FRD", 32'(FRD), 32'd1);
    chk("mrst_wrreq", 32'(wrreq), 32'd0);
    chk("mrst_data", 32'(data), 32'h00);
    chk("mrst_busy", 32'(rx_busy), 32'd0);
    chk("mrst_cnt", rx_cnt, 32'd0);
    repeat (2) @(negedge wrclk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge wrclk);
    push(8'hE2);
    wait_wrreq(8'hE2, s);
    repeat (8) @(negedge wrclk);

`ifdef FTDI_RX_CNT_EN
    @(negedge wrclk);
    force dut.rx_cnt_q = 32'hFFFF_FFFF;
    preload = 1'b1;
    @(negedge wrclk);
    preload = 1'b0;
    release dut.rx_cnt_q;
    push(8'h99);
    wait_wrreq(8'h99, s);
    repeat (2) @(negedge wrclk);
    chk("cnt_wrap", rx_cnt, 32'd0);
`else
    chk("cnt_tied", rx_cnt, 32'd0);
`endif
    repeat (4) @(negedge wrclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
